// File: rtl/sca_rdout_seq_pkg.sv
// Shared definitions for the SCA readout sequencer: state codes, block limits, watchdog limit.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package sca_rdout_seq_pkg;

  // Codes 1, 3 and 12 are decoded by the read-control logic and must not move.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_HOLD  = 4'd2,
    ST_FETCH = 4'd3,
    ST_CONV  = 4'd5,
    ST_STEP  = 4'd6,
    ST_END   = 4'd12
  } state_e;

  localparam logic [3:0] NBLK_MAX   = 4'd8;
  localparam logic [7:0] WDOG_LIMIT = 8'd255;

  // A block count outside 1..NBLK_MAX cannot be read out and is retired as an error.
  function automatic logic nblk_bad(input logic [3:0] n);
    return (n == 4'd0) || (n > NBLK_MAX);
  endfunction

endpackage

// File: rtl/sca_rdout_seq_conv_timer.sv
// ADC conversion-window timer: loadable down-counter, optionally triplicated with majority vote.
// Latency: DONE is high on the CONV_CYC-th cycle counting the START cycle as the first.
// Backpressure: none; a started window always runs to completion unless RST.
module conv_timer #(
  parameter int CONV_CYC = 12,
  parameter int TMR      = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
  output logic DONE
);

  localparam int         NREP   = (TMR != 0) ? 3 : 1;
  // START marks cycle 1, the first counted cycle is cycle 2, so the count ends at 0 on cycle CONV_CYC.
  localparam logic [5:0] RELOAD = 6'(CONV_CYC - 2);

  logic [5:0] cnt_q [NREP];
  logic       run_q [NREP];
  logic [5:0] cnt_v;
  logic       run_v;

  generate
    if (NREP == 3) begin : g_vote
      assign cnt_v = (cnt_q[0] & cnt_q[1]) | (cnt_q[0] & cnt_q[2]) | (cnt_q[1] & cnt_q[2]);
      assign run_v = (run_q[0] & run_q[1]) | (run_q[0] & run_q[2]) | (run_q[1] & run_q[2]);
    end else begin : g_single
      assign cnt_v = cnt_q[0];
      assign run_v = run_q[0];
    end
  endgenerate

  assign DONE = run_v && (cnt_v == 6'd0);

  // Every replica reloads from START and otherwise steps from the voted value, so a flipped copy heals.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREP; r++) begin
        cnt_q[r] <= '0;
        run_q[r] <= 1'b0;
      end
    end else begin
      for (int r = 0; r < NREP; r++) begin
        if (START) begin
          cnt_q[r] <= RELOAD;
          run_q[r] <= 1'b1;
        end else if (DONE) begin
          cnt_q[r] <= cnt_v;
          run_q[r] <= 1'b0;
        end else if (run_v) begin
          cnt_q[r] <= cnt_v - 6'd1;
          run_q[r] <= 1'b1;
        end else begin
          cnt_q[r] <= cnt_v;
          run_q[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sca_rdout_seq.sv
// SCA readout sequencer: pops one pending event, converts each of its blocks, retires it with TRGDONE/POPL1AN.
// Latency: 3 + NBLK*(CONV_CYC+1) cycles per event without back-pressure; each HOLD cycle adds one.
// Backpressure: DAQ_BUSY gates IDLE->LOAD and parks STEP in HOLD; SCA_RDOUT_TIMEOUT_EN adds a 255-cycle HOLD watchdog.
import sca_rdout_seq_pkg::*;

module sca_rdout_seq #(
  parameter int CONV_CYC = 12,
  parameter int TMR      = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TEMPTY,
  input  logic       DAQ_BUSY,
  input  logic [3:0] BLKIN,
  input  logic [3:0] NBLK,
  output logic [3:0] STATE,
  output logic [3:0] SCA_ADDR,
  output logic       ADC_CONV,
  output logic [3:0] SAMPLE,
  output logic       TRGDONE,
  output logic       POPL1AN,
  output logic       BUSY,
  output logic       RDERR
);

  state_e     state_q;
  logic [3:0] sca_addr_q;
  logic [3:0] sample_q;
  logic [3:0] rem_q;
  logic       adc_conv_q;
  logic       trgdone_q;
  logic       popl1an_q;
  logic       busy_q;
  logic       rderr_q;
  logic       conv_done;
`ifdef SCA_RDOUT_TIMEOUT_EN
  logic [7:0] wdog_q;
`endif

  // The registered strobe marks the first CONV cycle, which is exactly when the window starts.
  conv_timer #(
    .CONV_CYC (CONV_CYC),
    .TMR      (TMR)
  ) u_conv_timer (
    .CLK   (CLK),
    .RST   (RST),
    .START (adc_conv_q),
    .DONE  (conv_done)
  );

  // Sequencer FSM; strobes are set on the edge entering their state so every output is a flop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sca_addr_q <= '0;
      sample_q   <= '0;
      rem_q      <= '0;
      adc_conv_q <= 1'b0;
      trgdone_q  <= 1'b0;
      popl1an_q  <= 1'b0;
      busy_q     <= 1'b0;
      rderr_q    <= 1'b0;
`ifdef SCA_RDOUT_TIMEOUT_EN
      wdog_q     <= '0;
`endif
    end else begin
      adc_conv_q <= 1'b0;
      trgdone_q  <= 1'b0;
      popl1an_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!TEMPTY && !DAQ_BUSY) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          rderr_q <= 1'b0;
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          // The head entry is captured here; later TEMPTY/BLKIN/NBLK changes do not affect this event.
          sca_addr_q <= BLKIN;
          rem_q      <= NBLK;
          sample_q   <= '0;
          if (nblk_bad(NBLK)) begin
            rderr_q   <= 1'b1;
            state_q   <= ST_END;
            trgdone_q <= 1'b1;
            popl1an_q <= 1'b1;
          end else begin
            state_q    <= ST_CONV;
            adc_conv_q <= 1'b1;
          end
        end
        ST_CONV: begin
          if (conv_done) begin
            state_q <= ST_STEP;
          end
        end
        ST_STEP: begin
          rem_q <= rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_q   <= ST_END;
            trgdone_q <= 1'b1;
            popl1an_q <= 1'b1;
          end else begin
            sca_addr_q <= sca_addr_q + 4'd1;
            sample_q   <= sample_q + 4'd1;
            if (DAQ_BUSY) begin
              state_q <= ST_HOLD;
            end else begin
              state_q    <= ST_CONV;
              adc_conv_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!DAQ_BUSY) begin
            state_q    <= ST_CONV;
            adc_conv_q <= 1'b1;
`ifdef SCA_RDOUT_TIMEOUT_EN
            wdog_q     <= '0;
          end else if (wdog_q == WDOG_LIMIT - 8'd1) begin
            // This is the 255th consecutive HOLD cycle: give up and retire the event as an error.
            rderr_q   <= 1'b1;
            state_q   <= ST_END;
            trgdone_q <= 1'b1;
            popl1an_q <= 1'b1;
            wdog_q    <= '0;
          end else begin
            wdog_q <= wdog_q + 8'd1;
`endif
          end
        end
        ST_END: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign STATE    = state_q;
  assign SCA_ADDR = sca_addr_q;
  assign SAMPLE   = sample_q;
  assign ADC_CONV = adc_conv_q;
  assign TRGDONE  = trgdone_q;
  assign POPL1AN  = popl1an_q;
  assign BUSY     = busy_q;
  assign RDERR    = rderr_q;

endmodule

// File: tb/tb_sca_rdout_seq.sv
// Bench for sca_rdout_seq: scenario tasks with an address/sample scoreboard and latency expectations.
// Latency: expectations are computed per event from NBLK, CONV and the injected busy window.
// Backpressure: DAQ_BUSY windows are placed relative to a chosen conversion strobe.
module tb_sca_rdout_seq;

  localparam int CONV = 12;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b1;
  logic       TEMPTY   = 1'b1;
  logic       DAQ_BUSY = 1'b0;
  logic [3:0] BLKIN    = 4'd0;
  logic [3:0] NBLK     = 4'd0;
  logic [3:0] STATE;
  logic [3:0] SCA_ADDR;
  logic       ADC_CONV;
  logic [3:0] SAMPLE;
  logic       TRGDONE;
  logic       POPL1AN;
  logic       BUSY;
  logic       RDERR;

  int checks = 0;
  int passed = 0;

  logic [3:0] exp_addr [$];
  logic [3:0] exp_smp  [$];

  always #5 CLK = ~CLK;

  sca_rdout_seq #(
    .CONV_CYC (CONV),
    .TMR      (0)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TEMPTY   (TEMPTY),
    .DAQ_BUSY (DAQ_BUSY),
    .BLKIN    (BLKIN),
    .NBLK     (NBLK),
    .STATE    (STATE),
    .SCA_ADDR (SCA_ADDR),
    .ADC_CONV (ADC_CONV),
    .SAMPLE   (SAMPLE),
    .TRGDONE  (TRGDONE),
    .POPL1AN  (POPL1AN),
    .BUSY     (BUSY),
    .RDERR    (RDERR)
  );

  task automatic test_reset();
    int bad = 0;
    RST = 1'b1; TEMPTY = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (STATE !== 4'd0) $display("FAIL reset_state: got %0d want 0", STATE); else passed++;
    checks++; if ({SCA_ADDR, SAMPLE} !== 8'h00) $display("FAIL reset_addr_sample: got %h want 00", {SCA_ADDR, SAMPLE}); else passed++;
    checks++; if ({ADC_CONV, TRGDONE, POPL1AN, BUSY, RDERR} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {ADC_CONV, TRGDONE, POPL1AN, BUSY, RDERR}); else passed++;
    RST = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      if (STATE !== 4'd0 || BUSY !== 1'b0 || ADC_CONV !== 1'b0 || TRGDONE !== 1'b0 || POPL1AN !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_empty: %0d bad cycles, want 0", bad); else passed++;
  endtask

  task automatic test_idle_gate();
    int bad = 0;
    TEMPTY = 1'b0; DAQ_BUSY = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (STATE !== 4'd0 || BUSY !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_busy_gate: %0d cycles left IDLE, want 0", bad); else passed++;
    TEMPTY = 1'b1;
    @(negedge CLK);
    DAQ_BUSY = 1'b0;
    @(negedge CLK);
  endtask

  // One event: bconv>0 raises DAQ_BUSY at cycle bk of conversion bconv for blen cycles.
  task automatic run_event(input logic [3:0] blk, input logic [3:0] nb, input int bconv,
                           input int bk, input int blen, input string tag);
    int   nconv, hold, lat, conv_seen, prev_lat, exp_lat, exp_gap, busy_at;
    logic exp_err;
    bit   loaded, done;
    logic [3:0] ea, es;
    exp_err = (nb == 4'd0) || (nb > 4'd8);
    nconv   = exp_err ? 0 : int'(nb);
    hold    = 0;
    if (!exp_err && bconv > 0 && bconv < nconv && blen >= CONV - bk + 2) hold = blen - (CONV - bk + 1);
`ifdef SCA_RDOUT_TIMEOUT_EN
    if (hold > 255) begin hold = 255; exp_err = 1'b1; nconv = bconv; end
`endif
    for (int i = 0; i < nconv; i++) begin
      exp_addr.push_back(blk + 4'(i));
      exp_smp.push_back(4'(i));
    end
    exp_lat = 2 + nconv * (CONV + 1) + hold + 1;

    @(negedge CLK);
    BLKIN = blk; NBLK = nb; TEMPTY = 1'b0; DAQ_BUSY = 1'b0;
    lat = 0; loaded = 0; done = 0; conv_seen = 0; prev_lat = 0; busy_at = -1;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge CLK);
      if (!loaded && STATE === 4'd1) begin loaded = 1; lat = 1; end
      else if (loaded) lat++;
      if (loaded && lat == 2) begin
        TEMPTY = 1'b1;
        checks++; if (STATE !== 4'd3) $display("FAIL %s fetch_state: got %0d want 3", tag, STATE); else passed++;
        checks++; if (RDERR !== 1'b0) $display("FAIL %s rderr_cleared_by_load: got %b want 0", tag, RDERR); else passed++;
      end
      if (loaded && lat == 3) begin BLKIN = ~blk; NBLK = 4'd15; end
      if (ADC_CONV === 1'b1) begin
        if (exp_addr.size() == 0) begin
          checks++; $display("FAIL %s unexpected_conv: at lat %0d addr %0d", tag, lat, SCA_ADDR);
        end else begin
          ea = exp_addr.pop_front();
          es = exp_smp.pop_front();
          checks++; if (SCA_ADDR !== ea) $display("FAIL %s conv_addr: got %0d want %0d", tag, SCA_ADDR, ea); else passed++;
          checks++; if (SAMPLE !== es) $display("FAIL %s conv_sample: got %0d want %0d", tag, SAMPLE, es); else passed++;
          checks++; if (STATE !== 4'd5) $display("FAIL %s conv_state: got %0d want 5", tag, STATE); else passed++;
          if (conv_seen > 0) begin
            exp_gap = CONV + 1 + ((conv_seen == bconv) ? hold : 0);
            checks++; if (lat - prev_lat != exp_gap)
              $display("FAIL %s conv_gap: got %0d want %0d", tag, lat - prev_lat, exp_gap); else passed++;
          end
        end
        prev_lat = lat;
        conv_seen++;
        if (conv_seen == bconv) busy_at = lat + bk - 1;
      end
      if (busy_at >= 0 && lat == busy_at) DAQ_BUSY = 1'b1;
      if (busy_at >= 0 && lat == busy_at + blen) DAQ_BUSY = 1'b0;
      if (TRGDONE === 1'b1) begin
        done = 1;
        checks++; if (lat != exp_lat) $display("FAIL %s trgdone_latency: got %0d want %0d", tag, lat, exp_lat); else passed++;
        checks++; if (POPL1AN !== 1'b1) $display("FAIL %s popl1an_with_trgdone: got %b want 1", tag, POPL1AN); else passed++;
        checks++; if (RDERR !== exp_err) $display("FAIL %s rderr: got %b want %b", tag, RDERR, exp_err); else passed++;
        checks++; if (STATE !== 4'd12) $display("FAIL %s end_state: got %0d want 12", tag, STATE); else passed++;
      end
    end
    DAQ_BUSY = 1'b0;
    if (!done) begin
      checks++; $display("FAIL %s trgdone_timeout: no TRGDONE within 2000 cycles, want one", tag);
    end
    checks++; if (conv_seen != nconv) $display("FAIL %s conv_count: got %0d want %0d", tag, conv_seen, nconv); else passed++;
    @(negedge CLK);
    checks++; if (STATE !== 4'd0 || BUSY !== 1'b0 || TRGDONE !== 1'b0 || POPL1AN !== 1'b0)
      $display("FAIL %s back_to_idle: state %0d busy %b trg %b pop %b want 0 0 0 0", tag, STATE, BUSY, TRGDONE, POPL1AN);
    else passed++;
    exp_addr.delete();
    exp_smp.delete();
  endtask

  task automatic test_basic();      run_event(4'd5,  4'd3, 0, 0, 0, "basic");      endtask
  task automatic test_wrap();       run_event(4'd14, 4'd4, 0, 0, 0, "wrap");       endtask
  task automatic test_max_blocks(); run_event(4'd2,  4'd8, 0, 0, 0, "max_blocks"); endtask

  task automatic test_backpressure();
    run_event(4'd0, 4'd3, 2, 8, 10, "busy_mid_conv");
    run_event(4'd9, 4'd2, 1, 12, 1, "busy_conv_only");
    run_event(4'd9, 4'd2, 1, 12, 2, "busy_one_hold");
  endtask

  task automatic test_error();
    run_event(4'd3, 4'd0, 0, 0, 0, "nblk_zero");
    run_event(4'd3, 4'd9, 0, 0, 0, "nblk_nine");
    run_event(4'd3, 4'd1, 0, 0, 0, "after_error");
  endtask

  task automatic test_long_hold();
    run_event(4'd1, 4'd2, 1, 1, 300, "long_hold");
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    BLKIN = 4'd10; NBLK = 4'd1; TEMPTY = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      if (TRGDONE === 1'b1) seen = 1;
    end
    checks++; if (!seen) $display("FAIL b2b_first_done: no TRGDONE, want one"); else passed++;
    @(negedge CLK);
    checks++; if (STATE !== 4'd0) $display("FAIL b2b_idle_gap: got %0d want 0", STATE); else passed++;
    @(negedge CLK);
    checks++; if (STATE !== 4'd1) $display("FAIL b2b_reload: got %0d want 1", STATE); else passed++;
    TEMPTY = 1'b1;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      if (TRGDONE === 1'b1) seen = 1;
    end
    checks++; if (!seen || SCA_ADDR !== 4'd10)
      $display("FAIL b2b_second_done: seen %0d addr %0d want 1 10", seen, SCA_ADDR); else passed++;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int bad = 0;
    BLKIN = 4'd7; NBLK = 4'd3; TEMPTY = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge CLK);
      if (ADC_CONV === 1'b1) seen = 1;
    end
    checks++; if (!seen) $display("FAIL rst_mid_conv_start: no ADC_CONV, want one"); else passed++;
    repeat (3) @(negedge CLK);
    TEMPTY = 1'b1;
    #2 RST = 1'b1;
    #1;
    checks++; if (STATE !== 4'd0 || BUSY !== 1'b0) $display("FAIL rst_mid_state: state %0d busy %b want 0 0", STATE, BUSY); else passed++;
    checks++; if ({SCA_ADDR, SAMPLE, ADC_CONV, TRGDONE, POPL1AN, RDERR} !== 12'h000)
      $display("FAIL rst_mid_outputs: got %h want 000", {SCA_ADDR, SAMPLE, ADC_CONV, TRGDONE, POPL1AN, RDERR}); else passed++;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (30) begin
      @(negedge CLK);
      if (TRGDONE !== 1'b0 || POPL1AN !== 1'b0 || BUSY !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rst_mid_no_pop: %0d bad cycles, want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_basic();
    test_wrap();
    test_max_blocks();
    test_backpressure();
    test_error();
    test_long_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sca_rdout_seq.md
# sca_rdout_seq

Readout sequencer for the SCA read-control datapath. Pops one pending-event entry at a time, drives the 4-bit read `STATE` code, and walks through the event's SCA blocks. For each block it issues one ADC conversion window, then retires the entry with `TRGDONE` and `POPL1AN` pulses. It sits between the read-control FIFOs (empty flag, block address, block count) and the ADC/DAQ back end, and honours DAQ back-pressure.

## Interface
Parameters:
- `CONV_CYC`, default 12: length in clocks of one ADC conversion window; legal range 2..63.
- `TMR`, default 0: triplication flag, passed through to the sub-module.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset, asynchronous, active-high.
- `TEMPTY` in 1: pending-event FIFO empty.
- `DAQ_BUSY` in 1: downstream back-pressure; level-sensitive.
- `BLKIN` in 4: first SCA block address of the head entry.
- `NBLK` in 4: number of blocks to read for the head entry; legal 1..8.
- `STATE` out 4: current sequencer state code.
- `SCA_ADDR` out 4: SCA block currently being converted.
- `ADC_CONV` out 1: one-clock conversion-start strobe.
- `SAMPLE` out 4: index of the block in progress, 0-based.
- `TRGDONE` out 1: one-clock pulse; pops the pending-event FIFO.
- `POPL1AN` out 1: one-clock pulse; pops the L1A-number FIFO.
- `BUSY` out 1: high in every state except IDLE.
- `RDERR` out 1: sticky error flag; cleared on the next LOAD.

## Operation
State codes:
- IDLE=0, LOAD=1, HOLD=2, FETCH=3, CONV=5, STEP=6, END=12.
- All other codes are unreachable and recover to IDLE.

Transitions:
- IDLE→LOAD when `TEMPTY`=0 and `DAQ_BUSY`=0; otherwise stay in IDLE.
- LOAD→FETCH unconditionally. LOAD clears `RDERR`.
- FETCH: latch `BLKIN` into `SCA_ADDR` and `NBLK` into the remaining-block count; clear `SAMPLE`.
  - If `NBLK`=0 or `NBLK`>8: set `RDERR` and go to END. No conversion is issued.
  - Otherwise go to CONV.
- CONV: `ADC_CONV`=1 on the first cycle only. The timer counts `CONV_CYC` cycles, then the FSM goes to STEP.
- STEP:
  - Decrement the remaining count.
  - If the remaining count is now 0, go to END. `SCA_ADDR` and `SAMPLE` stay unchanged.
  - Otherwise increment `SCA_ADDR` (mod 16, so 15 wraps to 0) and `SAMPLE`, then:
    - if `DAQ_BUSY`=1, go to HOLD;
    - else go to CONV.
- HOLD→CONV on the first cycle with `DAQ_BUSY`=0.
- END: `TRGDONE`=1 and `POPL1AN`=1 for this one cycle, then go to IDLE.
- Back-to-back events: IDLE re-evaluates `TEMPTY` on the cycle after END, so the earliest next LOAD is END+2.

Boundary rules:
- `DAQ_BUSY` is ignored during LOAD, FETCH, CONV and END. A conversion is never aborted.
- `TEMPTY` rising mid-event has no effect. The head entry was latched in FETCH.
- `RST` mid-event: all state returns to reset values immediately. No `TRGDONE` is issued and the FIFOs are not popped.

Reset values: `STATE`=0, `SCA_ADDR`=0, `SAMPLE`=0, `ADC_CONV`=0, `TRGDONE`=0, `POPL1AN`=0, `BUSY`=0, `RDERR`=0.

## Timing
- All outputs are registered. `STATE` changes on the clock edge that enters a state.
- Event latency with no back-pressure: LOAD 1 + FETCH 1 + `NBLK`×(`CONV_CYC`+1) + END 1 cycles.
  - `NBLK`=8, `CONV_CYC`=12 → 107 cycles.
- `ADC_CONV` fires on the first cycle of each CONV, so consecutive strobes are `CONV_CYC`+1 cycles apart.
- Each HOLD cycle adds one cycle of delay.
- `TRGDONE` and `POPL1AN` are coincident, one pulse per event, including error events.

## Configuration
Macro: `SCA_RDOUT_TIMEOUT_EN`.
- Defined:
  - An 8-bit watchdog counts consecutive HOLD cycles.
  - When the count reaches 255, `RDERR` is set and the FSM goes to END. The event is retired normally, with `TRGDONE` and `POPL1AN`.
  - The watchdog clears on leaving HOLD.
- Undefined: HOLD waits indefinitely. No watchdog logic is present.

## Structure
- Shared package holds:
  - the state-code constants (IDLE..END), which must match the 4-bit `STATE` decode used by the read-control logic (1, 3 and 12 are fixed);
  - the `NBLK` maximum (8);
  - the watchdog limit (255).
- One sub-module, `conv_timer`: a loadable down-counter.
  - Ports: `CLK`, `RST`, `START`, `DONE`.
  - Parameter: `CONV_CYC`.
  - `DONE` is high on the last CONV cycle.

## Test plan
- Reset, then `TEMPTY`=1 for 50 cycles → `STATE`=0, `BUSY`=0, no strobes.
- `BLKIN`=5, `NBLK`=3, `CONV_CYC`=12 → `ADC_CONV` strobes at `SCA_ADDR` 5, 6, 7; then `TRGDONE` and `POPL1AN` together, 42 cycles after LOAD entry; then IDLE.
- `BLKIN`=14, `NBLK`=4 → `SCA_ADDR` sequence 14, 15, 0, 1; `SAMPLE` 0..3.
- `DAQ_BUSY` raised during the 2nd CONV for 10 cycles → that conversion completes, then HOLD for the remaining busy cycles, then the 3rd CONV. Total latency grows by the number of HOLD cycles.
- `NBLK`=0 → `RDERR`=1; no `ADC_CONV`; `TRGDONE` 3 cycles after LOAD entry. `RDERR` clears on the next LOAD.
- `RST` asserted mid-CONV → outputs return to reset values at once; no `TRGDONE`. With `SCA_RDOUT_TIMEOUT_EN`: holding `DAQ_BUSY`=1 for 300 cycles gives END with `RDERR`=1 after 255 HOLD cycles.
